// File: rtl/pico_mem_pkg.sv
// pico_mem_pkg
//   Shared definitions for the picorv32 memory/console slave: default console
//   address, the address-region type and the address decoder.
package pico_mem_pkg;

  localparam logic [31:0] CONSOLE_ADDR_DEF = 32'h1000_0000;

  typedef enum logic [1:0] {
    REG_RAM     = 2'd0,
    REG_CONSOLE = 2'd1,
    REG_ERR     = 2'd2
  } region_e;

  // The console register is matched first so it can never be shadowed by RAM
  // if a large MEM_WORDS ever grows the RAM window up to the console address.
  // ram_bytes is 33 bits so a full 4 GiB RAM window would still compare correctly.
  function automatic region_e decode_addr(input logic [31:0] addr,
                                          input logic [31:0] console_addr,
                                          input logic [32:0] ram_bytes);
    if (addr == console_addr) begin
      return REG_CONSOLE;
    end else if ({1'b0, addr} < ram_bytes) begin
      return REG_RAM;
    end else begin
      return REG_ERR;
    end
  endfunction

endpackage

// File: rtl/pico_byte_fifo.sv
// pico_byte_fifo
//   Small synchronous FIFO with an occupancy counter.
// Ports
//   clk, resetn        clock, asynchronous active-low reset
//   push, push_data    write request and data (ignored while full)
//   pop                read request (ignored while empty)
//   pop_data           head entry, valid while !empty
//   full, empty        derived from the registered count
//   count              number of stored entries, 0..DEPTH
module pico_byte_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem[rd_ptr_q];

  always_comb begin
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push_ok && !pop_ok) count_d = count_q + CNT_W'(1);
    if (pop_ok && !push_ok) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/pico_mem_console_slave.sv
// pico_mem_console_slave
//   picorv32 native-bus slave: word RAM with byte strobes, a console register
//   feeding a byte FIFO drained by a valid/ready stream, plus sticky watchdog
//   and character-count flags.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | waiting for a request; accepts unless a console write stalls
//   ST_RESP  | one-cycle completion: mem_ready=1, no new request accepted
//
// Ports
//   clk, resetn                 clock, asynchronous active-low reset
//   mem_valid/mem_instr         core request (mem_instr is informational)
//   mem_addr/mem_wdata/mem_wstrb byte address, write data, byte enables (0 = read)
//   mem_ready/mem_rdata         completion pulse and read data (0 outside ready)
//   con_valid/con_ready/con_data console byte stream out of the FIFO
//   bus_error                   pulses with mem_ready on a decode miss
//   wdog_expired, char_overflow sticky status flags
module pico_mem_console_slave
  import pico_mem_pkg::*;
#(
  parameter int unsigned MEM_WORDS    = 16384,
  parameter logic [31:0] CONSOLE_ADDR = CONSOLE_ADDR_DEF,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned WDOG_LIMIT   = 10000,
  parameter int unsigned CHAR_LIMIT   = 2000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic        mem_instr,
  output logic        mem_ready,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        con_valid,
  input  logic        con_ready,
  output logic [7:0]  con_data,
  output logic        bus_error,
  output logic        wdog_expired,
  output logic        char_overflow
);

  localparam int unsigned ADDR_W    = $clog2(MEM_WORDS);
  localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [32:0] RAM_BYTES = 33'(MEM_WORDS) << 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_e;

  state_e             state_q, state_d;
  region_e            region_q, region_d;
  logic               err_q, err_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [31:0]        wdog_q, wdog_d;
  logic               wdog_exp_q, wdog_exp_d;
  logic [15:0]        char_q, char_d;
  logic               char_ovf_q, char_ovf_d;

  logic [31:0]        ram [MEM_WORDS];
  logic [31:0]        ram_rd_q;
  logic [ADDR_W-1:0]  ram_idx;

  region_e            region;
  logic               is_wr, stall, accept, con_push, ram_we;
  logic               fifo_full, fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic               unused_instr;

  assign unused_instr = mem_instr;
  assign ram_idx      = mem_addr[ADDR_W+1:2];
  assign region       = decode_addr(mem_addr, CONSOLE_ADDR, RAM_BYTES);
  assign is_wr        = |mem_wstrb;

  // Full is the registered FIFO state: a pop in the same cycle does not
  // release the stall, the write is taken one cycle later.
  assign stall    = (region == REG_CONSOLE) && is_wr && fifo_full;
  assign accept   = (state_q == ST_IDLE) && mem_valid && !stall;
  assign con_push = accept && (region == REG_CONSOLE) && is_wr;
  assign ram_we   = accept && (region == REG_RAM) && is_wr;

  assign mem_ready     = (state_q == ST_RESP);
  assign bus_error     = err_q;
  assign mem_rdata     = !mem_ready          ? 32'h0 :
                         (region_q == REG_RAM) ? ram_rd_q : rdata_q;
  assign con_valid     = !fifo_empty;
  assign wdog_expired  = wdog_exp_q;
  assign char_overflow = char_ovf_q;

  always_comb begin
    state_d  = accept ? ST_RESP : ST_IDLE;
    region_d = region_q;
    err_d    = 1'b0;
    rdata_d  = 32'h0;
    if (accept) begin
      region_d = region;
      err_d    = (region == REG_ERR);
      if ((region == REG_CONSOLE) && !is_wr) rdata_d = 32'(fifo_count);
    end

    if (con_push) begin
      wdog_d = 32'h0;
    end else if (&wdog_q) begin
      wdog_d = wdog_q;
    end else begin
      wdog_d = wdog_q + 32'd1;
    end
    wdog_exp_d = wdog_exp_q | (wdog_d > WDOG_LIMIT);

    char_d = char_q;
    if (con_push && !(&char_q)) char_d = char_q + 16'd1;
    char_ovf_d = char_ovf_q | (char_d > 16'(CHAR_LIMIT));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      region_q   <= REG_RAM;
      err_q      <= 1'b0;
      rdata_q    <= 32'h0;
      wdog_q     <= 32'h0;
      wdog_exp_q <= 1'b0;
      char_q     <= 16'h0;
      char_ovf_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      region_q   <= region_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      wdog_q     <= wdog_d;
      wdog_exp_q <= wdog_exp_d;
      char_q     <= char_d;
      char_ovf_q <= char_ovf_d;
    end
  end

  // Read-first RAM: the read port captures the word before any lane update
  // in the same cycle, so a write completes with the old contents.
  always_ff @(posedge clk) begin
    if (accept) ram_rd_q <= ram[ram_idx];
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_wstrb[i]) ram[ram_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  pico_byte_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (con_push),
    .push_data (mem_wdata[7:0]),
    .pop       (con_ready),
    .pop_data  (con_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_pico_mem_console_slave.sv
module tb_pico_mem_console_slave;

  localparam logic [31:0] CON_ADDR = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        mem_valid, mem_instr, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        con_valid, con_ready;
  logic [7:0]  con_data;
  logic        bus_error, wdog_expired, char_overflow;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] rdata;
    logic        chk_rdata;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  con_exp_q[$];
  logic [31:0] ram_m [int];
  int          con_cnt_m;

  always #5 clk = ~clk;

  pico_mem_console_slave dut (
    .clk           (clk),
    .resetn        (resetn),
    .mem_valid     (mem_valid),
    .mem_instr     (mem_instr),
    .mem_ready     (mem_ready),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wstrb     (mem_wstrb),
    .mem_rdata     (mem_rdata),
    .con_valid     (con_valid),
    .con_ready     (con_ready),
    .con_data      (con_data),
    .bus_error     (bus_error),
    .wdog_expired  (wdog_expired),
    .char_overflow (char_overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Bus response monitor
  exp_t mon_e;
  always @(negedge clk) begin
    #2;
    if (mem_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ready: got ready with no pending request (t=%0t)", $time);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus_error !== mon_e.err || (mon_e.chk_rdata && mem_rdata !== mon_e.rdata)) begin
          errors++;
          $display("FAIL response: got rdata %h err %b expected rdata %h (checked %b) err %b (t=%0t)",
                   mem_rdata, bus_error, mon_e.rdata, mon_e.chk_rdata, mon_e.err, $time);
        end
      end
    end else begin
      checks++;
      if (mem_rdata !== 32'h0 || bus_error !== 1'b0) begin
        errors++;
        $display("FAIL idle_outputs: got rdata %h err %b expected 0 0 (t=%0t)", mem_rdata, bus_error, $time);
      end
    end
  end

  // Console stream monitor
  logic [7:0] mon_b;
  always @(negedge clk) begin
    #2;
    if (resetn && con_valid && con_ready) begin
      checks++;
      if (con_exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_byte: got %h with none expected (t=%0t)", con_data, $time);
      end else begin
        mon_b = con_exp_q.pop_front();
        if (con_data !== mon_b) begin
          errors++;
          $display("FAIL con_data: got %h expected %h (t=%0t)", con_data, mon_b, $time);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic xfer(input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input exp_t e);
    int n;
    @(negedge clk);
    mem_valid = 1'b1;
    mem_instr = 1'($urandom);
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = strb;
    exp_q.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_ready && n < 20);
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
    check("latency", n, 1);
  endtask

  task automatic ram_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    exp_t e;
    int idx;
    logic [31:0] w;
    idx = int'(addr[15:2]);
    e = '{rdata: 32'h0, chk_rdata: 1'b0, err: 1'b0};
    if (ram_m.exists(idx)) begin
      e.rdata = ram_m[idx];
      e.chk_rdata = 1'b1;
    end
    xfer(addr, data, strb, e);
    if (ram_m.exists(idx)) begin
      w = ram_m[idx];
      for (int b = 0; b < 4; b++) if (strb[b]) w[8*b +: 8] = data[8*b +: 8];
      ram_m[idx] = w;
    end else if (strb == 4'hF) begin
      ram_m[idx] = data;
    end
  endtask

  task automatic ram_read(input logic [31:0] addr);
    exp_t e;
    int idx;
    idx = int'(addr[15:2]);
    e = '{rdata: 32'h0, chk_rdata: 1'b0, err: 1'b0};
    if (ram_m.exists(idx)) begin
      e.rdata = ram_m[idx];
      e.chk_rdata = 1'b1;
    end
    xfer(addr, $urandom, 4'h0, e);
  endtask

  task automatic con_write(input logic [7:0] ch);
    logic [31:0] w;
    w = $urandom;
    w[7:0] = ch;
    con_exp_q.push_back(ch);
    xfer(CON_ADDR, w, 4'($urandom_range(1, 15)), '{rdata: 32'h0, chk_rdata: 1'b0, err: 1'b0});
  endtask

  task automatic con_read(input int cnt);
    xfer(CON_ADDR, $urandom, 4'h0, '{rdata: 32'(cnt), chk_rdata: 1'b1, err: 1'b0});
  endtask

  task automatic err_access(input logic [31:0] addr, input logic [3:0] strb);
    xfer(addr, $urandom, strb, '{rdata: 32'h0, chk_rdata: 1'b1, err: 1'b1});
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (con_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("drain_con_valid", con_valid, 0);
    check("drain_queue_empty", con_exp_q.size(), 0);
  endtask

  logic [31:0] addrs [16];

  initial begin
    resetn    = 1'b0;
    mem_valid = 1'b0;
    mem_instr = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    mem_wstrb = 4'h0;
    con_ready = 1'b0;
    #2;
    check("rst_mem_ready", mem_ready, 0);
    check("rst_mem_rdata", mem_rdata, 0);
    check("rst_bus_error", bus_error, 0);
    check("rst_con_valid", con_valid, 0);
    check("rst_wdog", wdog_expired, 0);
    check("rst_char", char_overflow, 0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;

    // Directed RAM and decode cases
    ram_write(32'h100, 32'hDEAD_BEEF, 4'hF);
    ram_read(32'h100);
    ram_write(32'h100, 32'h0000_00AA, 4'b0001);
    ram_read(32'h100);
    ram_read(32'h103);
    err_access(32'h2000_0000, 4'h0);
    err_access(32'h2000_0100, 4'hF);
    ram_read(32'h100);
    ram_write(32'h0000_FFFC, 32'h1234_5678, 4'hF);
    ram_read(32'h0000_FFFC);
    err_access(32'h0001_0000, 4'h0);
    con_read(0);

    // Console FIFO fill and stall
    for (int i = 0; i < 8; i++) con_write(8'h41 + 8'(i));
    con_read(8);
    @(negedge clk);
    mem_valid = 1'b1;
    mem_addr  = CON_ADDR;
    mem_wdata = 32'h0000_0049;
    mem_wstrb = 4'h1;
    exp_q.push_back('{rdata: 32'h0, chk_rdata: 1'b0, err: 1'b0});
    con_exp_q.push_back(8'h49);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_no_ready", mem_ready, 0);
    end
    con_ready = 1'b1;
    @(negedge clk);
    check("stall_pop_cycle", mem_ready, 0);
    @(negedge clk);
    check("stall_release", mem_ready, 1);
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
    wait_drain();

    // Randomized traffic against the model, console not drained
    con_ready = 1'b0;
    con_cnt_m = 0;
    for (int i = 0; i < 16; i++) begin
      addrs[i] = {16'h0, 14'($urandom_range(0, 16383)), 2'b00};
      ram_write(addrs[i], $urandom, 4'hF);
    end
    for (int n = 0; n < 300; n++) begin
      int r;
      logic [31:0] a;
      r = $urandom_range(0, 9);
      a = addrs[$urandom_range(0, 15)] | 32'($urandom_range(0, 3));
      if (r <= 3) begin
        ram_write(a, $urandom, 4'($urandom_range(1, 15)));
      end else if (r <= 6) begin
        ram_read(a);
      end else if (r == 7 && con_cnt_m < 8) begin
        con_write(8'($urandom));
        con_cnt_m++;
      end else if (r <= 8) begin
        con_read(con_cnt_m);
      end else begin
        err_access(32'h0001_0000 + 32'($urandom_range(0, 16'hFFFF)) * 4, 4'($urandom_range(0, 15)));
      end
    end
    con_ready = 1'b1;
    wait_drain();

    // Character-count guard
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 1; i <= 2001; i++) begin
      con_write(8'(i));
      if (i == 2000) check("char_ovf_at_2000", char_overflow, 0);
      if (i == 2001) check("char_ovf_at_2001", char_overflow, 1);
    end
    wait_drain();
    con_ready = 1'b0;
    con_write(8'h55);
    con_write(8'h66);
    check("pre_reset_con_valid", con_valid, 1);
    @(negedge clk);
    mem_valid = 1'b1;
    mem_addr  = CON_ADDR;
    mem_wstrb = 4'h0;
    @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    check("async_rst_ready", mem_ready, 0);
    check("async_rst_char", char_overflow, 0);
    check("async_rst_con_valid", con_valid, 0);
    check("async_rst_wdog", wdog_expired, 0);
    con_exp_q.delete();
    mem_valid = 1'b0;

    // Watchdog
    @(negedge clk);
    resetn = 1'b1;
    con_ready = 1'b1;
    for (int k = 1; k <= 10001; k++) begin
      @(negedge clk);
      if (k == 10000) check("wdog_at_10000", wdog_expired, 0);
      if (k == 10001) check("wdog_at_10001", wdog_expired, 1);
    end
    con_write(8'h5A);
    check("wdog_sticky", wdog_expired, 1);
    wait_drain();

    repeat (3) @(negedge clk);
    check("bus_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
